// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns debounced step pulses into one-cycle CPU enables, with free-run and PC breakpoint
module cpu_step_ctrl #(
   parameter int RUN_DIV       = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_pulse,
   input  logic             run_mode,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   output logic             cpu_en,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] step_count,
   output logic [2:0]       state
);
   localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, RUN, HALT} state_t;
   state_t st, st_nx;
   logic [DW-1:0] div, div_nx;
   logic [SW-1:0] settle, settle_nx;
   logic [CNT_W-1:0] cnt_nx;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= IDLE;
         div        <= '0;
         settle     <= '0;
         step_count <= '0;
      end else begin
         st         <= st_nx;
         div        <= div_nx;
         settle     <= settle_nx;
         step_count <= cnt_nx;
      end
   end
   always_comb begin
      st_nx     = st;
      div_nx    = div;
      settle_nx = settle;
      cnt_nx    = step_count;
      case (st)
         IDLE:
            if (run_mode) begin
               st_nx  = RUN;
               div_nx = '0;
            end else if (step_pulse) st_nx = ISSUE;
         ISSUE: begin
            cnt_nx    = step_count + CNT_W'(1);
            settle_nx = SW'(SETTLE_CYCLES - 1);
            st_nx     = SETTLE;
         end
         // pc is only compared on the last settle cycle
         SETTLE:
            if (settle != '0) settle_nx = settle - SW'(1);
            else if (bp_en && pc == bp_addr) st_nx = HALT;
            else if (run_mode) begin
               st_nx  = RUN;
               div_nx = '0;
            end else st_nx = IDLE;
         RUN:
            if (!run_mode) st_nx = IDLE;
            else if (div == DW'(RUN_DIV - 1)) st_nx = ISSUE;
            else div_nx = div + DW'(1);
         HALT:
            if (step_pulse) st_nx = ISSUE;
         default: st_nx = IDLE;
      endcase
   end
   assign cpu_en = st == ISSUE;
   assign busy   = st == ISSUE || st == SETTLE;
   assign halted = st == HALT;
   assign state  = st;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed checks of single-step, burst, free-run, breakpoint, wrap and async reset
module tb_cpu_step_ctrl;
   logic        clk = 0;
   logic        reset = 0;
   logic        step_pulse = 0;
   logic        run_mode = 0;
   logic        bp_en = 0;
   logic [31:0] bp_addr = 0;
   logic [31:0] pc = 0;
   logic        cpu_en, busy, halted;
   logic [15:0] step_count;
   logic [2:0]  state;
   logic        cpu_en4, busy4, halted4;
   logic [3:0]  step_count4;
   logic [2:0]  state4;
   int vectors = 0;
   int miscompares = 0;
   int en_cnt;
   cpu_step_ctrl dut (
      .clk(clk), .reset(reset), .step_pulse(step_pulse), .run_mode(run_mode),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en), .busy(busy),
      .halted(halted), .step_count(step_count), .state(state)
   );
   cpu_step_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .step_pulse(step_pulse), .run_mode(run_mode),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en4), .busy(busy4),
      .halted(halted4), .step_count(step_count4), .state(state4)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
   endtask
   task automatic pulse_step();
      step_pulse = 1;
      tick();
      en_cnt += int'(cpu_en);
      step_pulse = 0;
      repeat (3) begin
         tick();
         en_cnt += int'(cpu_en);
      end
   endtask
   initial begin
      int first, second;
      step_pulse = 1;
      run_mode = 1;
      #2 reset = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_cpu_en", cpu_en, 0);
         chk("rst_state", state, 0);
         chk("rst_count", step_count, 0);
      end
      reset = 0;
      tick();
      chk("rst_release_run", state, 3);
      run_mode = 0;
      step_pulse = 0;
      tick();
      chk("run_drop_idle", state, 0);
      step_pulse = 1;
      tick();
      step_pulse = 0;
      chk("step_cpu_en", cpu_en, 1);
      chk("step_busy", busy, 1);
      tick();
      chk("step_en_once", cpu_en, 0);
      chk("step_count1", step_count, 1);
      step_pulse = 1;
      tick();
      step_pulse = 0;
      chk("settle_drop_en", cpu_en, 0);
      tick();
      chk("settle_drop_en2", cpu_en, 0);
      chk("settle_drop_cnt", step_count, 1);
      chk("settle_to_idle", state, 0);
      chk("idle_not_busy", busy, 0);
      do_reset();
      en_cnt = 0;
      for (int i = 0; i < 46; i++) pulse_step();
      chk("burst_en", en_cnt, 46);
      chk("burst_count", step_count, 32'h2E);
      chk("burst_state", state, 0);
      do_reset();
      run_mode = 1;
      en_cnt = 0;
      first = -1;
      second = -1;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (cpu_en) begin
            en_cnt++;
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      chk("run_en", en_cnt, 10);
      chk("run_first", first, 5);
      chk("run_period", second - first, 7);
      tick();
      chk("run_state", state, 3);
      run_mode = 0;
      tick();
      chk("run_stop_idle", state, 0);
      repeat (10) begin
         tick();
         en_cnt += int'(cpu_en);
      end
      chk("run_stop_en", en_cnt, 10);
      do_reset();
      bp_en = 1;
      bp_addr = 32'h58;
      pc = 32'h58;
      run_mode = 1;
      repeat (8) tick();
      chk("bp_halted", halted, 1);
      chk("bp_state", state, 4);
      chk("bp_count", step_count, 1);
      en_cnt = 0;
      repeat (20) begin
         tick();
         en_cnt += int'(cpu_en);
      end
      chk("halt_no_en", en_cnt, 0);
      chk("halt_stays", halted, 1);
      step_pulse = 1;
      tick();
      step_pulse = 0;
      pc = 32'h5C;
      chk("halt_step_en", cpu_en, 1);
      repeat (3) tick();
      chk("resume_run", state, 3);
      chk("resume_halted", halted, 0);
      chk("resume_count", step_count, 2);
      run_mode = 0;
      pc = 32'h58;
      bp_en = 0;
      do_reset();
      en_cnt = 0;
      for (int i = 0; i < 17; i++) pulse_step();
      chk("wrap_count4", step_count4, 1);
      chk("wrap_count16", step_count, 17);
      chk("bp_off_idle", state, 0);
      step_pulse = 1;
      tick();
      step_pulse = 0;
      tick();
      chk("abort_settle", state, 2);
      chk("abort_busy_pre", busy, 1);
      #1 reset = 1;
      #1;
      chk("abort_state", state, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count4", step_count4, 0);
      tick();
      reset = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
